mini_src_ctrl: RTL and testbench

MINI_SRC_CTRL -- requirements
Module: mini_src_ctrl

---
 rtl/mini_src_pkg.sv | 50 +++++
 rtl/mini_src_ctrl_if.sv | 33 +++
 rtl/mini_src_opdec.sv | 31 +++
 rtl/mini_src_ctrl.sv | 152 +++++++++++++++
 tb/tb_mini_src_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mini_src_pkg.sv
// mini_src_pkg: shared constants for the Mini SRC control unit.
//   state_t   - control-step encoding (S_RST, T0..T7, S_HALT)
//   iclass_t  - instruction classes produced by mini_src_opdec
//   OP_*      - opcode field values (ir[31:27])
//   ALU_*     - ALU operation selects driven on alu_control
package mini_src_pkg;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_BR, C_JR, C_NOP, C_HALT, C_ILL
  } iclass_t;

  localparam logic [4:0] OP_LD       = 5'b00000;
  localparam logic [4:0] OP_LDI      = 5'b00001;
  localparam logic [4:0] OP_ST       = 5'b00010;
  localparam logic [4:0] OP_ADD      = 5'b00011;
  localparam logic [4:0] OP_SUB      = 5'b00100;
  localparam logic [4:0] OP_AND      = 5'b00101;
  localparam logic [4:0] OP_OR       = 5'b00110;
  localparam logic [4:0] OP_ALU_LAST = 5'b01010;
  localparam logic [4:0] OP_ADDI     = 5'b01011;
  localparam logic [4:0] OP_ANDI     = 5'b01100;
  localparam logic [4:0] OP_ORI      = 5'b01101;
  localparam logic [4:0] OP_MUL      = 5'b01110;
  localparam logic [4:0] OP_DIV      = 5'b01111;
  localparam logic [4:0] OP_BR       = 5'b10010;
  localparam logic [4:0] OP_JR       = 5'b10011;
  localparam logic [4:0] OP_NOP      = 5'b11001;
  localparam logic [4:0] OP_HALT     = 5'b11010;

  // Register ALU ops use their opcode as the ALU select; INC sits in an unused slot.
  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = OP_ADD;
  localparam logic [4:0] ALU_AND  = OP_AND;
  localparam logic [4:0] ALU_OR   = OP_OR;
  localparam logic [4:0] ALU_INC  = 5'b10100;

  // Immediate forms reuse the ALU operation of their register counterpart.
  function automatic logic [4:0] imm_base_op(input logic [4:0] op);
    case (op)
      OP_ADDI: return ALU_ADD;
      OP_ANDI: return ALU_AND;
      default: return ALU_OR;
    endcase
  endfunction

endpackage

// File: rtl/mini_src_ctrl_if.sv
// mini_src_ctrl_if: control bus between the Mini SRC control unit and datapath.
//   ir, con_ff, mem_rdy         - status into the controller
//   Pout..ConIn                 - one-bit datapath strobes
//   alu_control                 - ALU operation select
//   Run, Illegal                - executing / sticky undecodable-opcode flag
//   modport master = controller, modport slave = datapath
interface mini_src_ctrl_if;
  import mini_src_pkg::*;

  logic [31:0] ir;
  logic        con_ff, mem_rdy;
  logic        Pout, MARen, MDRen, Read, Write, MDRout, IRen, Pen;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen;
  logic        ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, ConIn;
  logic [4:0]  alu_control;
  logic        Run, Illegal;

  modport master (
    input  ir, con_ff, mem_rdy,
    output Pout, MARen, MDRen, Read, Write, MDRout, IRen, Pen,
           Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen,
           ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, ConIn,
           alu_control, Run, Illegal
  );

  modport slave (
    output ir, con_ff, mem_rdy,
    input  Pout, MARen, MDRen, Read, Write, MDRout, IRen, Pen,
           Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yen,
           ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen, ConIn,
           alu_control, Run, Illegal
  );
endinterface

// File: rtl/mini_src_opdec.sv
// mini_src_opdec: combinational opcode -> instruction class decoder.
//   opcode - ir[31:27]
//   iclass - instruction class (C_ILL for anything undecodable)
// Option: MINI_SRC_CTRL_MULDIV_EN makes mul/div decode as C_MULDIV; otherwise illegal.
module mini_src_opdec
  import mini_src_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass
);

  always_comb begin
    iclass = C_ILL;
    case (opcode) inside
      OP_LD:                  iclass = C_LD;
      OP_LDI:                 iclass = C_LDI;
      OP_ST:                  iclass = C_ST;
      [OP_ADD:OP_ALU_LAST]:   iclass = C_ALU;
      [OP_ADDI:OP_ORI]:       iclass = C_IMM;
`ifdef MINI_SRC_CTRL_MULDIV_EN
      OP_MUL, OP_DIV:         iclass = C_MULDIV;
`endif
      OP_BR:                  iclass = C_BR;
      OP_JR:                  iclass = C_JR;
      OP_NOP:                 iclass = C_NOP;
      OP_HALT:                iclass = C_HALT;
      default:                iclass = C_ILL;
    endcase
  end

endmodule

// File: rtl/mini_src_ctrl.sv
// mini_src_ctrl: Moore control-step FSM for the Mini SRC processor.
//   clk - clock, rising edge
//   clr - asynchronous active-low reset
//   bus - mini_src_ctrl_if.master (ir/con_ff/mem_rdy in, strobes/alu_control/Run/Illegal out)
// Option: MINI_SRC_CTRL_MULDIV_EN enables the mul/div sequence (see mini_src_opdec).
module mini_src_ctrl
  import mini_src_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  mini_src_ctrl_if.master bus
);

  state_t     state, nxt;
  iclass_t    iclass;
  logic       illegal_q, set_illegal, rst_sync_n;
  logic [4:0] opcode;

  assign opcode = bus.ir[31:27];

  mini_src_opdec u_opdec (.opcode(opcode), .iclass(iclass));

  // clr asserts immediately; its release is retimed by one edge so the first
  // S_RST -> T0 step never races the deassertion.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) rst_sync_n <= 1'b0;
    else      rst_sync_n <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state <= nxt;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    nxt         = state;
    set_illegal = 1'b0;
    case (state)
      S_RST: nxt = S_T0;
      S_T0:  nxt = S_T1;
      S_T1:  if (bus.mem_rdy) nxt = S_T2;
      S_T2:  nxt = S_T3;
      S_T3:
        case (iclass)
          C_JR, C_NOP: nxt = S_T0;
          C_HALT:      nxt = S_HALT;
          C_ILL: begin
            nxt         = S_HALT;
            set_illegal = 1'b1;
          end
          default:     nxt = S_T4;
        endcase
      S_T4:  nxt = S_T5;
      // A not-taken branch skips T6 entirely, keeping T6 outputs a pure function of state.
      S_T5:
        case (iclass)
          C_LD, C_ST, C_MULDIV: nxt = S_T6;
          C_BR:                 nxt = bus.con_ff ? S_T6 : S_T0;
          default:              nxt = S_T0;
        endcase
      S_T6:
        case (iclass)
          C_LD:    if (bus.mem_rdy) nxt = S_T7;
          C_ST:    nxt = S_T7;
          default: nxt = S_T0;
        endcase
      S_T7:  if (iclass != C_ST || bus.mem_rdy) nxt = S_T0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_RST;
    endcase
  end

  always_comb begin
    bus.Pout = 1'b0;   bus.MARen = 1'b0;  bus.MDRen = 1'b0;  bus.Read = 1'b0;
    bus.Write = 1'b0;  bus.MDRout = 1'b0; bus.IRen = 1'b0;   bus.Pen = 1'b0;
    bus.Gra = 1'b0;    bus.Grb = 1'b0;    bus.Grc = 1'b0;    bus.Rin = 1'b0;
    bus.Rout = 1'b0;   bus.BAout = 1'b0;  bus.Cout = 1'b0;   bus.Yen = 1'b0;
    bus.ZLOen = 1'b0;  bus.ZHIen = 1'b0;  bus.ZLOout = 1'b0; bus.ZHIout = 1'b0;
    bus.HIen = 1'b0;   bus.LOen = 1'b0;   bus.ConIn = 1'b0;
    bus.alu_control = ALU_NONE;
    bus.Run     = (state != S_RST) && (state != S_HALT);
    bus.Illegal = illegal_q;
    case (state)
      S_T0: begin
        bus.Pout = 1'b1; bus.MARen = 1'b1; bus.ZLOen = 1'b1; bus.alu_control = ALU_INC;
      end
      S_T1: begin
        bus.ZLOout = 1'b1; bus.Pen = 1'b1; bus.Read = 1'b1; bus.MDRen = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRen = 1'b1;
      end
      S_T3:
        case (iclass)
          C_LD, C_LDI, C_ST:   begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yen = 1'b1; end
          C_ALU, C_IMM, C_MULDIV: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yen = 1'b1; end
          C_BR: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.ConIn = 1'b1; end
          C_JR: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Pen = 1'b1; end
          default: ;
        endcase
      S_T4:
        case (iclass)
          C_LD, C_LDI, C_ST: begin
            bus.Cout = 1'b1; bus.ZLOen = 1'b1; bus.alu_control = ALU_ADD;
          end
          C_ALU: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZLOen = 1'b1; bus.alu_control = opcode;
          end
          C_IMM: begin
            bus.Cout = 1'b1; bus.ZLOen = 1'b1; bus.alu_control = imm_base_op(opcode);
          end
          C_MULDIV: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZLOen = 1'b1; bus.ZHIen = 1'b1;
            bus.alu_control = opcode;
          end
          C_BR: begin bus.Pout = 1'b1; bus.Yen = 1'b1; end
          default: ;
        endcase
      S_T5:
        case (iclass)
          C_LD, C_ST:          begin bus.ZLOout = 1'b1; bus.MARen = 1'b1; end
          C_LDI, C_ALU, C_IMM: begin bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_MULDIV:            begin bus.ZLOout = 1'b1; bus.LOen = 1'b1; end
          C_BR: begin
            bus.Cout = 1'b1; bus.ZLOen = 1'b1; bus.alu_control = ALU_ADD;
          end
          default: ;
        endcase
      S_T6:
        case (iclass)
          C_LD:     begin bus.Read = 1'b1; bus.MDRen = 1'b1; end
          C_ST:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRen = 1'b1; end
          C_MULDIV: begin bus.ZHIout = 1'b1; bus.HIen = 1'b1; end
          C_BR:     begin bus.ZLOout = 1'b1; bus.Pen = 1'b1; end
          default: ;
        endcase
      S_T7:
        case (iclass)
          C_LD:    begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_ST:    bus.Write = 1'b1;
          default: ;
        endcase
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mini_src_ctrl.sv
// tb_mini_src_ctrl: scoreboard bench for mini_src_ctrl. The driver expands each
// instruction into its per-cycle output vectors (from the instruction's step
// list) and queues them; a monitor pops and compares one vector per cycle.
module tb_mini_src_ctrl;
  import mini_src_pkg::*;

  typedef logic [29:0] vec_t;
  localparam vec_t POUT   = 30'h1 << 0;
  localparam vec_t MAREN  = 30'h1 << 1;
  localparam vec_t MDREN  = 30'h1 << 2;
  localparam vec_t READ   = 30'h1 << 3;
  localparam vec_t WRITE  = 30'h1 << 4;
  localparam vec_t MDROUT = 30'h1 << 5;
  localparam vec_t IREN   = 30'h1 << 6;
  localparam vec_t PEN    = 30'h1 << 7;
  localparam vec_t GRA    = 30'h1 << 8;
  localparam vec_t GRB    = 30'h1 << 9;
  localparam vec_t GRC    = 30'h1 << 10;
  localparam vec_t RIN    = 30'h1 << 11;
  localparam vec_t ROUT   = 30'h1 << 12;
  localparam vec_t BAOUT  = 30'h1 << 13;
  localparam vec_t COUT   = 30'h1 << 14;
  localparam vec_t YEN    = 30'h1 << 15;
  localparam vec_t ZLOEN  = 30'h1 << 16;
  localparam vec_t ZHIEN  = 30'h1 << 17;
  localparam vec_t ZLOOUT = 30'h1 << 18;
  localparam vec_t ZHIOUT = 30'h1 << 19;
  localparam vec_t HIEN   = 30'h1 << 20;
  localparam vec_t LOEN   = 30'h1 << 21;
  localparam vec_t CONIN  = 30'h1 << 22;
  localparam vec_t RUN    = 30'h1 << 28;
  localparam vec_t ILL    = 30'h1 << 29;
`ifdef MINI_SRC_CTRL_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  function automatic vec_t alu(input logic [4:0] c);
    return vec_t'(c) << 23;
  endfunction

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mini_src_ctrl_if bus();
  mini_src_ctrl dut (.clk(clk), .clr(clr), .bus(bus.master));

  vec_t dut_vec;
  assign dut_vec = {bus.Illegal, bus.Run, bus.alu_control, bus.ConIn, bus.LOen, bus.HIen,
                    bus.ZHIout, bus.ZLOout, bus.ZHIen, bus.ZLOen, bus.Yen, bus.Cout,
                    bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Pen,
                    bus.IRen, bus.MDRout, bus.Write, bus.Read, bus.MDRen, bus.MARen, bus.Pout};

  vec_t sb[$];
  vec_t ph_v[$];
  bit   ph_w[$];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic check(input string name, input vec_t got, input vec_t exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      check("cycle", dut_vec, e);
    end
  end

  function automatic void addp(input vec_t v, input bit w);
    ph_v.push_back(v | RUN);
    ph_w.push_back(w);
  endfunction

  // Step list of one instruction; w=1 marks a step that waits for mem_rdy.
  task automatic plan(input logic [4:0] op, input bit con, output bit halts, output vec_t hv);
    ph_v.delete();
    ph_w.delete();
    halts = 1'b0;
    hv    = '0;
    addp(POUT | MAREN | ZLOEN | alu(ALU_INC), 1'b0);
    addp(ZLOOUT | PEN | READ | MDREN, 1'b1);
    addp(MDROUT | IREN, 1'b0);
    if (op == 5'd0 || op == 5'd1 || op == 5'd2) begin
      addp(GRB | BAOUT | YEN, 1'b0);
      addp(COUT | ZLOEN | alu(ALU_ADD), 1'b0);
      if (op == 5'd1) addp(ZLOOUT | GRA | RIN, 1'b0);
      else begin
        addp(ZLOOUT | MAREN, 1'b0);
        if (op == 5'd0) begin
          addp(READ | MDREN, 1'b1);
          addp(MDROUT | GRA | RIN, 1'b0);
        end else begin
          addp(GRA | ROUT | MDREN, 1'b0);
          addp(WRITE, 1'b1);
        end
      end
    end else if (op >= 5'd3 && op <= 5'd10) begin
      addp(GRB | ROUT | YEN, 1'b0);
      addp(GRC | ROUT | ZLOEN | alu(op), 1'b0);
      addp(ZLOOUT | GRA | RIN, 1'b0);
    end else if (op >= 5'd11 && op <= 5'd13) begin
      addp(GRB | ROUT | YEN, 1'b0);
      addp(COUT | ZLOEN | alu(op == 5'd11 ? ALU_ADD : op == 5'd12 ? OP_AND : OP_OR), 1'b0);
      addp(ZLOOUT | GRA | RIN, 1'b0);
    end else if ((op == 5'd14 || op == 5'd15) && MULDIV) begin
      addp(GRB | ROUT | YEN, 1'b0);
      addp(GRC | ROUT | ZLOEN | ZHIEN | alu(op), 1'b0);
      addp(ZLOOUT | LOEN, 1'b0);
      addp(ZHIOUT | HIEN, 1'b0);
    end else if (op == 5'd18) begin
      addp(GRA | ROUT | CONIN, 1'b0);
      addp(POUT | YEN, 1'b0);
      addp(COUT | ZLOEN | alu(ALU_ADD), 1'b0);
      if (con) addp(ZLOOUT | PEN, 1'b0);
    end else if (op == 5'd19) begin
      addp(GRA | ROUT | PEN, 1'b0);
    end else if (op == 5'd25) begin
      addp('0, 1'b0);
    end else if (op == 5'd26) begin
      addp('0, 1'b0);
      halts = 1'b1;
    end else begin
      addp('0, 1'b0);
      halts = 1'b1;
      hv    = ILL;
    end
  endtask

  task automatic cyc(input vec_t v, input bit rdy);
    bus.mem_rdy = rdy;
    sb.push_back(v);
    @(posedge clk);
    #1;
  endtask

  // Called just after a negedge sample with clr already low.
  task automatic release_reset();
    @(posedge clk);
    #1;
    clr = 1'b1;
    cyc('0, 1'b0);
    cyc('0, 1'b0);
  endtask

  task automatic assert_reset(input string name);
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    #1;
    clr = 1'b0;
    #1;
    check(name, dut_vec, '0);
    release_reset();
  endtask

  // Runs one instruction from T0. fstall<0 picks a random fetch stall;
  // abort_ph>=0 pulls clr in the middle of that step.
  task automatic run_instr(input logic [31:0] irw, input bit con, input int fstall,
                           input int abort_ph);
    bit   halts;
    vec_t hv;
    logic [4:0] op;
    op = irw[31:27];
    plan(op, con, halts, hv);
    bus.ir     = irw;
    bus.con_ff = con;
    for (int i = 0; i < ph_v.size(); i++) begin
      if (i == abort_ph) begin
        sb.push_back(ph_v[i]);
        assert_reset("async_reset");
        return;
      end
      if (ph_w[i]) begin
        int k;
        k = (i == 1 && fstall >= 0) ? fstall : int'($urandom_range(0, 3));
        repeat (k) cyc(ph_v[i], 1'b0);
      end
      cyc(ph_v[i], ph_w[i] ? 1'b1 : 1'($urandom));
    end
    if (halts) begin
      repeat (20) cyc(hv, 1'($urandom));
      assert_reset("halt_reset");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] legal [13];
    legal = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd10, 5'd11, 5'd12, 5'd13,
              5'd14, 5'd18, 5'd19, 5'd25};
    clr         = 1'b0;
    bus.ir      = '0;
    bus.con_ff  = 1'b0;
    bus.mem_rdy = 1'b0;
    #2;
    check("reset_state", dut_vec, '0);
    release_reset();

    run_instr({OP_NOP, 27'h0}, 1'b0, 3, -1);                               // fetch stall x3
    run_instr({OP_LD, 4'd1, 4'd2, 19'h55}, 1'b0, -1, -1);                  // ld R1,0x55(R2)
    run_instr({OP_BR, 4'd3, 4'd0, 19'h10}, 1'b0, -1, -1);                  // br not taken
    run_instr({OP_BR, 4'd3, 4'd0, 19'h10}, 1'b1, -1, -1);                  // br taken
    run_instr({OP_MUL, 4'd1, 4'd2, 4'd3, 15'h0}, 1'b0, -1, -1);            // mul
    run_instr({OP_ST, 4'd4, 4'd5, 19'h7}, 1'b0, -1, 6);                    // reset mid-T6 of st
    run_instr({OP_LD, 4'd4, 4'd5, 19'h7}, 1'b0, -1, 6);                    // reset during ld stall

    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      if ($urandom_range(0, 9) == 0) op = 5'($urandom);
      else op = legal[$urandom_range(0, 12)];
      run_instr({op, 27'($urandom)}, 1'($urandom), -1, -1);
    end

    run_instr({5'b11111, 27'h0}, 1'b0, -1, -1);                            // illegal, 20-cycle hold
    run_instr({OP_HALT, 27'h0}, 1'b0, -1, -1);                             // halt

    repeat (3) @(negedge clk);
    #1;
    check("sb_empty", vec_t'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
